adc_captura_spi: RTL

Sampling front end directly upstream of the 200 Hz low-pass filter.
- Paces conversions of a 12-bit serial ADC (ADCS7476-type: 4 leading zeros, 12 data bits MSB first) with a free-running sample-rate counter.
- Clocks each frame in over SPI and converts the unsigned code to a signed N-bit fixed-point sample.
- Presents the sample on `Uk` with a one-cycle `Bandera_ADC` strobe, which the filter consumes unchanged.

---
 rtl/adc_pkg.sv | 16 +
 rtl/divisor_sclk.sv | 57 +++++
 rtl/adc_captura_spi.sv | 125 ++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC capture front end: FSM states and
// frame geometry of the 16-bit ADCS7476-style frame.
package adc_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    PREPARA,
    DESPLAZA,
    PUBLICA
  } estado_t;

  localparam int ADC_BITS   = 12;
  localparam int LEAD_BITS  = 4;
  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/divisor_sclk.sv
// SCLK generator: DIV-cycle half periods over 16 bit slots, with a capture
// strobe on the first high cycle of each slot and a flag on the final cycle.
module divisor_sclk
  import adc_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic sclk,
  output logic capture,
  output logic last
);

  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(FRAME_BITS);

  logic [HW-1:0] half_cnt;
  logic [SW-1:0] slot;
  logic          half_end;

  assign half_end = (half_cnt == HW'(DIV - 1));
  assign capture  = en & sclk & (half_cnt == '0);
  assign last     = en & sclk & half_end & (slot == SW'(FRAME_BITS - 1));

  // start pre-loads the first low half so sclk falls as the shift phase begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk     <= 1'b1;
      half_cnt <= '0;
      slot     <= '0;
    end else if (start) begin
      sclk     <= 1'b0;
      half_cnt <= '0;
      slot     <= '0;
    end else if (en) begin
      if (half_end) begin
        half_cnt <= '0;
        if (sclk) begin
          slot <= slot + 1'b1;
          sclk <= last;
        end else begin
          sclk <= 1'b1;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end else begin
      sclk     <= 1'b1;
      half_cnt <= '0;
      slot     <= '0;
    end
  end

endmodule

// File: rtl/adc_captura_spi.sv
// Paced SPI capture of a 12-bit offset-binary ADC, published as a signed
// Q(N-FRAC).FRAC sample with a one-cycle strobe for the downstream filter.
module adc_captura_spi
  import adc_pkg::*;
#(
  parameter int N             = 25,
  parameter int FRAC          = 15,
  parameter int DIV           = 4,
  parameter int SAMPLE_PERIOD = 10000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sdata,
  output logic                       cs_n,
  output logic                       sclk,
  output logic signed [N-1:0]        Uk,
  output logic                       Bandera_ADC,
  output logic [ADC_BITS-1:0]        Dato_ADC,
  output logic                       Error_Trama
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  estado_t               estado;
  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [PW-1:0]         prep_cnt;
  logic                  prep_done;
  logic                  start;
  logic                  en;
  logic                  capture;
  logic                  last;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_next;

  // Offset binary to two's complement, then align the 11 fraction bits to FRAC.
  function automatic logic signed [N-1:0] to_q(input logic [ADC_BITS-1:0] code);
    logic signed [ADC_BITS-1:0] s;
    logic signed [N-1:0]        ext;
    s   = {~code[ADC_BITS-1], code[ADC_BITS-2:0]};
    ext = {{(N - ADC_BITS){s[ADC_BITS-1]}}, s};
    return ext <<< (FRAC - (ADC_BITS - 1));
  endfunction

  assign tick       = (cnt == CW'(SAMPLE_PERIOD - 1));
  assign prep_done  = (prep_cnt == PW'(DIV - 1));
  assign start      = (estado == PREPARA) && prep_done;
  assign en         = (estado == DESPLAZA);
  // With DIV=1 the last bit arrives on the same edge the frame is published.
  assign frame_next = capture ? {shreg[FRAME_BITS-2:0], sdata} : shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  divisor_sclk #(
    .DIV(DIV)
  ) u_divisor (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .en     (en),
    .sclk   (sclk),
    .capture(capture),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    shreg <= frame_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      cs_n        <= 1'b1;
      prep_cnt    <= '0;
      Uk          <= '0;
      Dato_ADC    <= '0;
      Error_Trama <= 1'b0;
      Bandera_ADC <= 1'b0;
    end else begin
      Bandera_ADC <= 1'b0;
      case (estado)
        REPOSO: begin
          if (tick) begin
            estado   <= PREPARA;
            cs_n     <= 1'b0;
            prep_cnt <= '0;
          end
        end
        PREPARA: begin
          if (prep_done) begin
            estado <= DESPLAZA;
          end else begin
            prep_cnt <= prep_cnt + 1'b1;
          end
        end
        DESPLAZA: begin
          if (last) begin
            estado      <= PUBLICA;
            cs_n        <= 1'b1;
            Bandera_ADC <= 1'b1;
            Uk          <= to_q(frame_next[ADC_BITS-1:0]);
            Dato_ADC    <= frame_next[ADC_BITS-1:0];
            Error_Trama <= |frame_next[FRAME_BITS-1 -: LEAD_BITS];
          end
        end
        PUBLICA: begin
          estado <= REPOSO;
        end
        default: begin
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule
